// File: rtl/bit_pack_streamer.sv
// Packs MSB-aligned variable-length chunks into a dense MSB-first stream of OUT_W-bit words,
// flagging the final word with its valid-bit count (optionally rounded up to ALIGN_W).
module bit_pack_streamer #(
   parameter int OUT_W   = 8,
   parameter int IN_W    = 16,
   parameter int ALIGN_W = 1
) (
   input  logic                       clk_i,
   input  logic                       rst_i,
   input  logic [IN_W-1:0]            data_i,
   input  logic [$clog2(IN_W+1)-1:0]  len_i,
   input  logic                       last_i,
   input  logic                       vld_i,
   output logic                       rdy_o,
   output logic [OUT_W-1:0]           data_o,
   output logic [$clog2(OUT_W+1)-1:0] bits_o,
   output logic                       last_o,
   output logic                       vld_o,
   input  logic                       rdy_i,
   output logic                       idle_o
);

   localparam int BUF_W = OUT_W + IN_W;
   localparam int FW    = $clog2(BUF_W + 1);
   localparam int LW    = $clog2(IN_W + 1);
   localparam int BW    = $clog2(OUT_W + 1);
   localparam logic [FW-1:0] OUT_F = FW'(OUT_W);
   localparam logic [FW-1:0] BUF_F = FW'(BUF_W);
   localparam logic [LW-1:0] IN_L  = LW'(IN_W);

   typedef enum logic [1:0] {IDLE, ACTIVE, DRAIN} state_e;

   state_e            state_q, state_d;
   logic [BUF_W-1:0]  buf_q, buf_d, placed;
   logic [FW-1:0]     fill_q, fill_d, fill_eff;
   logic [IN_W-1:0]   chunk;
   logic              pop, push;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         buf_q   <= '0;
         fill_q  <= '0;
      end else begin
         state_q <= state_d;
         buf_q   <= buf_d;
         fill_q  <= fill_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      vld_o    = (state_q == DRAIN) || ((state_q == ACTIVE) && (fill_q >= OUT_F));
      last_o   = (state_q == DRAIN) && (fill_q <= OUT_F);
      data_o   = buf_q[BUF_W-1 -: OUT_W];
      idle_o   = (state_q == IDLE) && (fill_q == '0);
      bits_o   = '0;
      if (vld_o)
         bits_o = last_o ? BW'(((int'(fill_q) + ALIGN_W - 1) / ALIGN_W) * ALIGN_W) : BW'(OUT_W);

      pop      = vld_o && rdy_i;
      fill_eff = fill_q;
      if (pop)
         fill_eff = (fill_q >= OUT_F) ? fill_q - OUT_F : '0;
      rdy_o    = (state_q != DRAIN) && (fill_eff < OUT_F);
      push     = vld_i && rdy_o;

      // Keep only the top len_i bits, then drop them in right after the bits already held.
      chunk    = data_i & ~({IN_W{1'b1}} >> len_i);
      placed   = {chunk, {OUT_W{1'b0}}} >> fill_eff;
      buf_d    = pop ? (buf_q << OUT_W) : buf_q;
      fill_d   = fill_eff;
      if (push) begin
         buf_d  = buf_d | placed;
         fill_d = fill_eff + FW'(len_i);
      end

      case (state_q)
         IDLE, ACTIVE:
            if (push) state_d = last_i ? DRAIN : ACTIVE;
         DRAIN:
            if (pop && last_o) begin
               state_d = IDLE;
               buf_d   = '0;
               fill_d  = '0;
            end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         assert (!(vld_i && (len_i > IN_L)));
         assert (fill_q < BUF_F);
      end
   end

endmodule

// File: tb/tb_bit_pack_streamer.sv
// Bench for bit_pack_streamer: a bit-queue reference model scores two instances
// (8/8/1 and 8/16/4) under directed and randomized streams with random backpressure.
module tb_bit_pack_streamer;

   typedef struct { logic [15:0] d; int len; bit last; } chunk_t;
   typedef struct { logic [7:0] d; int bits; bit last; } word_t;

   logic clk = 0, rst = 1;
   always #5 clk = ~clk;

   logic [7:0]  d0_data; logic [3:0] d0_len; logic d0_last, d0_vld, d0_rdyo, d0_rdyi;
   logic [7:0]  d0_out;  logic [3:0] d0_bits; logic d0_lasto, d0_vldo, d0_idle;
   logic [15:0] d1_data; logic [4:0] d1_len; logic d1_last, d1_vld, d1_rdyo, d1_rdyi;
   logic [7:0]  d1_out;  logic [3:0] d1_bits; logic d1_lasto, d1_vldo, d1_idle;

   bit_pack_streamer #(.OUT_W(8), .IN_W(8), .ALIGN_W(1)) dut0 (
      .clk_i(clk), .rst_i(rst), .data_i(d0_data), .len_i(d0_len), .last_i(d0_last),
      .vld_i(d0_vld), .rdy_o(d0_rdyo), .data_o(d0_out), .bits_o(d0_bits), .last_o(d0_lasto),
      .vld_o(d0_vldo), .rdy_i(d0_rdyi), .idle_o(d0_idle));

   bit_pack_streamer #(.OUT_W(8), .IN_W(16), .ALIGN_W(4)) dut1 (
      .clk_i(clk), .rst_i(rst), .data_i(d1_data), .len_i(d1_len), .last_i(d1_last),
      .vld_i(d1_vld), .rdy_o(d1_rdyo), .data_o(d1_out), .bits_o(d1_bits), .last_o(d1_lasto),
      .vld_o(d1_vldo), .rdy_i(d1_rdyi), .idle_o(d1_idle));

   int nchk = 0, nerr = 0;
   chunk_t cq[$];
   word_t  wq[$], obs[$];
   bit     bitq[$];

   // Reference: bits accumulate in a queue; whole words leave as soon as they exist,
   // and a final chunk flushes the remainder as one zero-padded word.
   task automatic model_push(input chunk_t c, input int iw, input int al);
      word_t w;
      int rem;
      for (int i = 0; i < c.len; i++) bitq.push_back(c.d[iw-1-i]);
      while (bitq.size() > 8 || (!c.last && bitq.size() == 8)) begin
         w.d = '0;
         for (int i = 0; i < 8; i++) w.d[7-i] = bitq.pop_front();
         w.bits = 8; w.last = 0;
         wq.push_back(w);
      end
      if (c.last) begin
         rem = bitq.size();
         w.d = '0;
         for (int i = 0; i < rem; i++) w.d[7-i] = bitq.pop_front();
         w.bits = ((rem + al - 1) / al) * al; w.last = 1;
         wq.push_back(w);
      end
   endtask

   task automatic drv0(input bit v, input logic [7:0] d, input int len, input bit l, input bit r);
      @(negedge clk);
      d0_vld = v; d0_data = d; d0_len = 4'(len); d0_last = l; d0_rdyi = r;
      #1;
   endtask

   task automatic run(input int sel, input int rprob, output int ncyc);
      int iw, al;
      bit have, rdy, rdyo, ov, ol, oi;
      logic [7:0] od; int ob;
      chunk_t c;
      word_t e;
      iw = sel ? 16 : 8; al = sel ? 4 : 1;
      ncyc = 0; obs.delete();
      while (ncyc < 2000) begin
         @(negedge clk);
         have = cq.size() > 0;
         c = have ? cq[0] : '{16'h0, 0, 1'b0};
         rdy = ($urandom_range(99) < rprob);
         if (sel == 0) begin
            d0_vld = have; d0_data = c.d[7:0]; d0_len = 4'(c.len); d0_last = c.last; d0_rdyi = rdy;
         end else begin
            d1_vld = have; d1_data = c.d; d1_len = 5'(c.len); d1_last = c.last; d1_rdyi = rdy;
         end
         #1;
         if (sel == 0) begin
            rdyo = d0_rdyo; ov = d0_vldo; od = d0_out; ob = int'(d0_bits); ol = d0_lasto; oi = d0_idle;
         end else begin
            rdyo = d1_rdyo; ov = d1_vldo; od = d1_out; ob = int'(d1_bits); ol = d1_lasto; oi = d1_idle;
         end
         if (!have && wq.size() == 0 && oi) break;
         if (ov && rdy) begin
            nchk++;
            if (wq.size() == 0) begin
               nerr++;
               $display("FAIL unexpected_word dut%0d: got %h bits %0d last %0d, required none", sel, od, ob, ol);
            end else begin
               e = wq.pop_front();
               if (od !== e.d || ob != e.bits || ol !== e.last) begin
                  nerr++;
                  $display("FAIL word dut%0d: got %h bits %0d last %0d, required %h bits %0d last %0d",
                           sel, od, ob, ol, e.d, e.bits, e.last);
               end
            end
            obs.push_back('{od, ob, ol});
         end
         if (have && rdyo) begin
            model_push(c, iw, al);
            void'(cq.pop_front());
         end
         ncyc++;
      end
      nchk++;
      if (ncyc >= 2000) begin
         nerr++;
         $display("FAIL timeout dut%0d: %0d chunks and %0d words left, required 0", sel, cq.size(), wq.size());
      end
      d0_vld = 0; d1_vld = 0;
   endtask

   task automatic do_reset();
      @(negedge clk); rst = 1;
      @(negedge clk); rst = 0;
      bitq.delete(); wq.delete(); cq.delete();
   endtask

   task automatic test_reset();
      @(negedge clk); rst = 1;
      @(negedge clk); #1;
      nchk++;
      if ({d0_vldo, d0_rdyo, d0_idle, d0_lasto, d0_out, d0_bits} !== {3'b011, 1'b0, 8'h00, 4'd0} ||
          {d1_vldo, d1_rdyo, d1_idle, d1_lasto, d1_out, d1_bits} !== {3'b011, 1'b0, 8'h00, 4'd0}) begin
         nerr++;
         $display("FAIL reset: dut0 v%b r%b i%b l%b %h %0d, dut1 v%b r%b i%b l%b %h %0d, required v0 r1 i1 l0 00 0",
                  d0_vldo, d0_rdyo, d0_idle, d0_lasto, d0_out, d0_bits,
                  d1_vldo, d1_rdyo, d1_idle, d1_lasto, d1_out, d1_bits);
      end
      rst = 0;
   endtask

   task automatic test_basic();
      int n;
      cq = '{'{16'h00A0, 4, 0}, '{16'h00B0, 4, 0}, '{16'h00C0, 4, 1}};
      run(0, 100, n);
      nchk++;
      if (obs.size() != 2 || obs[0].d !== 8'hAB || obs[1].d !== 8'hC0 || obs[1].bits != 4 || !d0_idle) begin
         nerr++;
         $display("FAIL basic: %0d words idle %b, required AB,C0(4) idle 1", obs.size(), d0_idle);
      end
   endtask

   task automatic test_masking();
      int n;
      cq = '{'{16'h00FF, 3, 0}, '{16'h00FF, 0, 0}, '{16'h0000, 5, 1}};
      run(0, 100, n);
      nchk++;
      if (obs.size() < 1 || obs[0].d !== 8'hE0 || obs[0].bits != 8) begin
         nerr++;
         $display("FAIL masking: first word %h, required e0 bits 8", obs.size() ? obs[0].d : 8'hxx);
      end
   endtask

   task automatic test_backpressure();
      drv0(1, 8'h11, 8, 0, 0);
      nchk++; if (d0_rdyo !== 1) begin nerr++; $display("FAIL bp_first_rdy: got %b required 1", d0_rdyo); end
      for (int i = 0; i < 3; i++) begin
         drv0(1, 8'h22, 8, 0, 0);
         nchk++;
         if (d0_rdyo !== 0 || d0_vldo !== 1 || d0_out !== 8'h11 || d0_bits !== 4'd8) begin
            nerr++;
            $display("FAIL bp_hold: rdy %b vld %b data %h bits %0d, required 0 1 11 8", d0_rdyo, d0_vldo, d0_out, d0_bits);
         end
      end
      drv0(1, 8'h22, 8, 0, 1);
      nchk++;
      if (d0_rdyo !== 1 || d0_out !== 8'h11) begin
         nerr++; $display("FAIL bp_release: rdy %b data %h, required 1 11", d0_rdyo, d0_out);
      end
      drv0(0, 8'h00, 0, 0, 1);
      nchk++;
      if (d0_vldo !== 1 || d0_out !== 8'h22) begin
         nerr++; $display("FAIL bp_second: vld %b data %h, required 1 22", d0_vldo, d0_out);
      end
      drv0(1, 8'h5A, 0, 1, 1);
      nchk++;
      if (d0_vldo !== 0 || d0_rdyo !== 1) begin
         nerr++; $display("FAIL bp_empty_push: vld %b rdy %b, required 0 1", d0_vldo, d0_rdyo);
      end
      drv0(0, 8'h00, 0, 0, 1);
      nchk++;
      if ({d0_vldo, d0_out, d0_bits, d0_lasto, d0_rdyo} !== {1'b1, 8'h00, 4'd0, 1'b1, 1'b0}) begin
         nerr++;
         $display("FAIL empty_word: vld %b data %h bits %0d last %b rdy %b, required 1 00 0 1 0",
                  d0_vldo, d0_out, d0_bits, d0_lasto, d0_rdyo);
      end
      drv0(0, 8'h00, 0, 0, 1);
      nchk++; if (d0_idle !== 1) begin nerr++; $display("FAIL bp_idle: got %b required 1", d0_idle); end
   endtask

   task automatic test_back_to_back();
      int n;
      for (int i = 0; i < 10; i++) cq.push_back('{16'($urandom_range(255)), 8, 0});
      cq.push_back('{16'($urandom_range(255)), 0, 1});
      run(0, 100, n);
      nchk++;
      if (n > 12 || obs.size() != 11) begin
         nerr++; $display("FAIL throughput: %0d cycles %0d words, required <=12 cycles 11 words", n, obs.size());
      end
   endtask

   task automatic test_align();
      int n;
      cq = '{'{16'hABC0, 12, 1}};
      run(1, 100, n);
      cq = '{'{16'hFC00, 6, 1}};
      run(1, 100, n);
      nchk++;
      if (obs.size() != 1 || obs[0].d !== 8'hFC || obs[0].bits != 8 || obs[0].last !== 1) begin
         nerr++;
         $display("FAIL align: %0d words, first %h bits %0d, required fc bits 8 last 1",
                  obs.size(), obs.size() ? obs[0].d : 8'hxx, obs.size() ? obs[0].bits : -1);
      end
   endtask

   task automatic test_random();
      int n, iw, nc;
      for (int s = 0; s < 12; s++) begin
         iw = (s % 2) ? 16 : 8;
         nc = $urandom_range(12, 1);
         for (int i = 0; i < nc; i++)
            cq.push_back('{16'($urandom_range(65535)) & ((iw == 8) ? 16'h00FF : 16'hFFFF),
                           int'($urandom_range(iw)), i == nc - 1});
         run(s % 2, 60, n);
      end
   endtask

   task automatic test_mid_reset();
      drv0(1, 8'hFF, 8, 0, 0);
      drv0(1, 8'h0F, 4, 0, 0);
      nchk++; if (d0_vldo !== 1) begin nerr++; $display("FAIL midrst_pre: vld %b required 1", d0_vldo); end
      d0_vld = 0;
      do_reset();
      #1;
      nchk++;
      if ({d0_vldo, d0_lasto, d0_idle, d0_rdyo, d0_out} !== {4'b0011, 8'h00}) begin
         nerr++;
         $display("FAIL midrst: vld %b last %b idle %b rdy %b data %h, required 0 0 1 1 00",
                  d0_vldo, d0_lasto, d0_idle, d0_rdyo, d0_out);
      end
   endtask

   initial begin
      d0_vld = 0; d0_data = 0; d0_len = 0; d0_last = 0; d0_rdyi = 1;
      d1_vld = 0; d1_data = 0; d1_len = 0; d1_last = 0; d1_rdyi = 1;
      test_reset();
      test_basic();
      test_masking();
      test_backpressure();
      test_back_to_back();
      test_align();
      test_random();
      test_mid_reset();
      $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
      $finish;
   end

endmodule
